// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e  : fetch FSM states
//   ResetPcDefault : default PC loaded on reset
//   NopInst        : instruction substituted for a faulted fetch (addi x0, x0, 0)
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StOut,
    StHalt
  } fetch_state_e;

  localparam logic [31:0] ResetPcDefault = 32'h8000_0000;
  localparam logic [31:0] NopInst        = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's handshake channels.
//   imem_req_*   : request channel to instruction memory (valid/ready)
//   imem_resp_*  : response channel from instruction memory (valid only)
//   out_*        : fetched instruction towards decode (valid/ready)
//   redirect_*   : PC replacement from execute
// Modport master is the fetch unit; slave is its environment (memory, decode, execute).
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            imem_resp_err;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_fault;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data, imem_resp_err,
    output out_valid, out_inst, out_pc, out_fault,
    input  out_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data, imem_resp_err,
    input  out_valid, out_inst, out_pc, out_fault,
    output out_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one instruction-memory request at a time,
// and hands each fetched word with its PC to decode. Redirects from execute replace the PC
// at any time; a response belonging to a request issued before the redirect is discarded.
// A faulted fetch is delivered as a NOP with out_fault set, after which fetching halts
// until the next redirect.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : fetch_unit_if master (memory request/response, decode output, redirect)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(ResetPcDefault)
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;  // an issued request's response must be thrown away
  logic [XLEN-1:0] out_inst_q, out_inst_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            out_fault_q, out_fault_d;

  logic [XLEN-1:0] redir_pc;
  logic            req_fire;
  logic            out_fire;

  assign redir_pc = bus.redirect_pc & ~XLEN'(3);
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  assign bus.imem_req_valid = (state_q == StReq);
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = (state_q == StOut);
  assign bus.out_inst       = out_inst_q;
  assign bus.out_pc         = out_pc_q;
  assign bus.out_fault      = out_fault_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_fault_d = out_fault_q;
    unique case (state_q)
      StIdle: begin
        if (bus.redirect_valid) pc_d = redir_pc;
        state_d = StReq;
      end
      StReq: begin
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
          // Old-PC request accepted this cycle: its response is stale
          if (req_fire) begin
            drop_d  = 1'b1;
            state_d = StWait;
          end
        end else if (req_fire) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.imem_resp_valid && bus.redirect_valid) begin
          // Outstanding response consumed here, so nothing is left to drop
          pc_d    = redir_pc;
          drop_d  = 1'b0;
          state_d = StReq;
        end else if (bus.imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            out_inst_d  = bus.imem_resp_err ? XLEN'(NopInst) : bus.imem_resp_data;
            out_pc_d    = pc_q;
            out_fault_d = bus.imem_resp_err;
            state_d     = StOut;
          end
        end else if (bus.redirect_valid) begin
          pc_d   = redir_pc;
          drop_d = 1'b1;
        end
      end
      StOut: begin
        // Redirect squashes the presented instruction even if decode takes it
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          state_d = StReq;
        end else if (out_fire) begin
          if (out_fault_q) begin
            state_d = StHalt;
          end else begin
            pc_d    = pc_q + XLEN'(4);
            state_d = StReq;
          end
        end
      end
      StHalt: begin
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      out_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_fault_q <= out_fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder with configurable latency, directed scenarios
// followed by randomized ready/redirect/reset traffic. Expected deliveries come from an
// architectural PC-stream model: each delivered instruction is the next PC in program order
// (start, +4 per delivery, replaced by each redirect), and a faulting address halts fetch.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RstPc   = 32'h8000_0000;
  localparam logic [31:0] FaultPc = 32'h8000_0054;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(RstPc)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Memory contents: the reset word is fixed, all other words are a bijective hash of the
  // address so that a response from the wrong address is always distinguishable.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == RstPc) return 32'h0010_0093;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit mem_err(input logic [31:0] a);
    return a[8:2] == 7'h15;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    return mem_err(a) ? 32'h0000_0013 : mem_data(a);
  endfunction

  // ---------------- memory responder ----------------
  bit          pend;
  bit          resp_real;
  logic [31:0] pend_addr;
  int          wait_cnt;
  int          mem_delay  = 0;
  bit          rand_delay = 0;
  bit          spurious   = 0;
  int          acc_count  = 0;

  initial begin
    pend = 0;
    resp_real = 0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.imem_resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0;
      end else begin
        if (resp_real) pend = 0;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          check("one_outstanding", {31'b0, pend}, 32'd0);
          pend      = 1;
          pend_addr = bus.imem_req_addr;
          wait_cnt  = rand_delay ? int'($urandom_range(0, mem_delay)) : mem_delay;
          acc_count++;
        end
      end
      @(posedge clk);
      #1;
      resp_real = 0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom;
      bus.imem_resp_err   = 1'b0;
      if (!rst && pend) begin
        if (wait_cnt == 0) begin
          resp_real = 1;
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_data  = mem_data(pend_addr);
          bus.imem_resp_err   = mem_err(pend_addr);
        end else begin
          wait_cnt--;
        end
      end else if (!rst && spurious && ($urandom % 8 == 0)) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_err   = 1'($urandom);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_q[$];
  bit          halted;
  bit          prev_stall;
  logic [31:0] st_inst, st_pc;
  logic        st_fault;
  int          hs_count = 0;

  initial begin
    halted = 0;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q = {RstPc};
        halted = 0;
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
          check("stall_inst", bus.out_inst, st_inst);
          check("stall_pc", bus.out_pc, st_pc);
          check("stall_fault", {31'b0, bus.out_fault}, {31'b0, st_fault});
        end
        if (halted) check("halt_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_delivery");
          end else begin
            logic [31:0] pc;
            pc = exp_q.pop_front();
            check("out_pc", bus.out_pc, pc);
            check("out_inst", bus.out_inst, exp_inst(pc));
            check("out_fault", {31'b0, bus.out_fault}, {31'b0, mem_err(pc)});
            if (mem_err(pc)) halted = 1;
            else exp_q.push_back(pc + 32'd4);
          end
        end
        if (bus.redirect_valid) begin
          exp_q.delete();
          exp_q.push_back(bus.redirect_pc & ~32'd3);
          halted = 0;
        end
        prev_stall = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
        st_inst  = bus.out_inst;
        st_pc    = bus.out_pc;
        st_fault = bus.out_fault;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller at the negedge of the cycle presenting the request.
  task automatic wait_req(input logic [31:0] exp, input string name);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.imem_req_valid;
    end
    if (!seen) fail_now({name, "_timeout"});
    else check(name, bus.imem_req_addr, exp);
  endtask

  task automatic redirect(input logic [31:0] pc);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    int acc0, hs0;
    bit seen;
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_inst", bus.out_inst, 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_fault", {31'b0, bus.out_fault}, 32'd0);
    step();
    rst = 1'b0;

    // First fetch and response-to-output latency
    wait_req(RstPc, "first_req_addr");
    @(negedge clk);
    check("resp_cycle_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("first_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("first_out_inst", bus.out_inst, 32'h0010_0093);
    check("first_out_pc", bus.out_pc, RstPc);

    // Decode stalls for five cycles
    repeat (5) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_req(RstPc + 32'd4, "next_req_addr");
    check("one_handshake", 32'(hs_count), 32'd1);

    // Redirect while waiting, stale response arrives later
    mem_delay = 3;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    step();
    bus.redirect_valid = 1'b0;
    wait_req(32'h8000_0100, "redirect_wait_addr");

    // Redirect coincident with the response
    mem_delay = 1;
    @(posedge clk);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0040;
    step();
    bus.redirect_valid = 1'b0;
    wait_req(32'h8000_0040, "redirect_resp_addr");
    acc0 = acc_count;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    if (!seen) fail_now("redirect_resp_deliver_timeout");
    else check("redirect_resp_single_req", 32'(acc_count - acc0), 32'd1);

    // Fetch fault halts until redirect
    mem_delay = 0;
    redirect(FaultPc);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = halted;
    end
    if (!seen) fail_now("fault_halt_timeout");
    repeat (10) @(posedge clk);
    redirect(32'h8000_0200);
    wait_req(32'h8000_0200, "halt_exit_addr");

    // Redirect squashes an instruction decode would otherwise accept
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      seen = bus.out_valid;
    end
    if (!seen) fail_now("squash_out_timeout");
    hs0 = hs_count;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0103;
    step();
    bus.redirect_valid = 1'b0;
    check("squash_no_handshake", 32'(hs_count), 32'(hs0));
    wait_req(32'h8000_0100, "squash_addr");

    // PC wrap-around
    redirect(32'hFFFF_FFF8);
    repeat (30) @(posedge clk);

    // Randomized traffic with one mid-run reset
    rand_delay = 1;
    mem_delay  = 3;
    spurious   = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c == 1500) begin
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        step();
        rst = 1'b0;
      end
      bus.out_ready      = ($urandom % 4) != 0;
      bus.imem_req_ready = ($urandom % 3) != 0;
      bus.redirect_valid = ($urandom % 16) == 0;
      bus.redirect_pc    = 32'h8000_0000 + ($urandom_range(0, 255) * 4) + ($urandom % 4);
    end
    step();
    bus.redirect_valid = 1'b0;
    repeat (10) @(posedge clk);
    check("progress", {31'b0, hs_count > 200}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
